// File: rtl/uart_host_link_pkg.sv
// uart_host_link_pkg: shared UART state encoding, frame constants and baud helper
package uart_host_link_pkg;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_host_link_fifo.sv
// uart_host_link_fifo: first-word fall-through byte buffer for the receive path
module uart_host_link_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign valid_o = cnt_q != '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign data_o  = mem_q[rd_q];
    assign do_pop  = pop_i & valid_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Storage and pointers; a pop frees the head slot so a push may land in the same cycle when full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_host_link.sv
// uart_host_link: host-side 8N1 UART peer with stream TX and buffered stream RX
module uart_host_link
    import uart_host_link_pkg::*;
#(
    parameter int SYS_CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    output logic       rx_frame_err
);
    localparam int            CPB  = clks_per_bit(SYS_CLK_FREQ, BAUD_RATE);
    localparam int            CW   = $clog2(CPB) + 1;
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] MID  = CW'(CPB / 2);

    uart_state_e   tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic          tx_line_q, tx_line_d;
    logic [1:0]    sync_q;
    logic          rx_s, rx_wait_q, rx_wait_d, rx_push, fifo_full;
    logic          rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;

    assign tx_ready     = tx_state_q == UART_IDLE;
    assign uart_tx      = tx_line_q;
    assign rx_s         = sync_q[1];
    assign rx_overrun   = rx_ovr_q;
    assign rx_frame_err = rx_ferr_q;

    // TX next state: shift the latched byte out LSB first; line level is registered to stay glitch-free
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            UART_IDLE: begin
                tx_cnt_d = '0;
                if (tx_valid) begin
                    tx_state_d = UART_START;
                    tx_shift_d = tx_data;
                end
            end
            UART_START: if (tx_cnt_q == LAST) begin
                tx_state_d = UART_DATA;
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
            end
            UART_DATA: if (tx_cnt_q == LAST) begin
                tx_cnt_d   = '0;
                tx_shift_d = tx_shift_q >> 1;
                tx_bit_d   = tx_bit_q + 1'b1;
                if (tx_bit_q == 3'(DATA_BITS - 1)) tx_state_d = UART_STOP;
            end
            UART_STOP: if (tx_cnt_q == LAST) begin
                tx_state_d = UART_IDLE;
                tx_cnt_d   = '0;
            end
            default: tx_state_d = UART_IDLE;
        endcase
        tx_line_d = tx_state_d == UART_START ? 1'b0 :
                    tx_state_d == UART_DATA  ? tx_shift_d[0] : 1'b1;
    end

    // RX next state: mid-bit sampling; after a framing error, wait for an idle-high line before re-arming
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_wait_d  = rx_wait_q & ~rx_s;
        rx_push    = 1'b0;
        rx_ovr_d   = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            UART_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_s && !rx_wait_q) rx_state_d = UART_START;
            end
            UART_START: if (rx_cnt_q == MID) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s ? UART_IDLE : UART_DATA;
            end
            UART_DATA: if (rx_cnt_q == LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 1'b1;
                if (rx_bit_q == 3'(DATA_BITS - 1)) rx_state_d = UART_STOP;
            end
            UART_STOP: if (rx_cnt_q == LAST) begin
                rx_cnt_d   = '0;
                rx_state_d = UART_IDLE;
                rx_push    = rx_s;
                rx_ovr_d   = rx_s & fifo_full & ~rx_ready;
                rx_ferr_d  = ~rx_s;
                rx_wait_d  = ~rx_s;
            end
            default: rx_state_d = UART_IDLE;
        endcase
    end

    // State registers for both directions plus the uart_rx synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= UART_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
            sync_q     <= 2'b11;
            rx_state_q <= UART_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_wait_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            sync_q     <= {sync_q[0], uart_rx};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_wait_q  <= rx_wait_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    uart_host_link_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (rx_push),
        .data_i (rx_shift_q),
        .pop_i  (rx_ready),
        .data_o (rx_data),
        .valid_o(rx_valid),
        .full_o (fifo_full)
    );

endmodule
